// File: rtl/mac_accum.sv
// mac_accum: accumulates LEN unsigned 16-bit products into a saturating sum,
// then holds the result under a valid/ready handshake until it is consumed.
module mac_accum #(
    parameter int LEN   = 8,
    parameter int ACC_W = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      prod,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc,
    output logic             ovf,
    output logic [7:0]       cnt
);
    typedef enum logic {ACC, HOLD} state_t;
    localparam logic [7:0] LEN_C = 8'(LEN);
    state_t           r_state, w_state_nxt;
    logic [ACC_W-1:0] r_acc, w_acc_nxt;
    logic             r_ovf, w_ovf_nxt;
    logic [7:0]       r_cnt, w_cnt_nxt, w_cnt_inc;
    logic [ACC_W:0]   w_sum;
    logic             w_xfer;
    assign in_ready  = (r_state == ACC) && !clear;
    assign w_xfer    = in_valid && in_ready;
    assign w_sum     = {1'b0, r_acc} + (ACC_W+1)'(prod);
    assign w_cnt_inc = r_cnt + 8'd1;
    assign out_valid = (r_state == HOLD);
    assign acc       = r_acc;
    assign ovf       = r_ovf;
    assign cnt       = r_cnt;
    // Clear and result consumption share one path; a transfer can only occur without clear.
    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_ovf_nxt   = r_ovf;
        w_cnt_nxt   = r_cnt;
        if (clear || (r_state == HOLD && out_ready)) begin
            w_state_nxt = ACC;
            w_acc_nxt   = '0;
            w_ovf_nxt   = 1'b0;
            w_cnt_nxt   = '0;
        end else if (w_xfer) begin
            w_acc_nxt   = w_sum[ACC_W] ? '1 : w_sum[ACC_W-1:0];
            w_ovf_nxt   = r_ovf | w_sum[ACC_W];
            w_cnt_nxt   = w_cnt_inc;
            w_state_nxt = (w_cnt_inc == LEN_C) ? HOLD : ACC;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ACC;
        end else begin
            r_state <= w_state_nxt;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
            r_cnt <= '0;
        end else begin
            r_acc <= w_acc_nxt;
            r_ovf <= w_ovf_nxt;
            r_cnt <= w_cnt_nxt;
        end
    end
endmodule
